// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dual dispatch, dual CDB snoop, dual in-order retire with speculation tags.
// Optional ROB_DEBUG_EN exposes count/head/tail as dbg_* ports.
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     disp0_valid,
  input  logic [4:0]               disp0_arn,
  input  logic [5:0]               disp0_rrn,
  input  logic                     disp0_tag,
  input  logic                     disp1_valid,
  input  logic [4:0]               disp1_arn,
  input  logic [5:0]               disp1_rrn,
  input  logic                     disp1_tag,
  output logic                     disp_ready,
  input  logic                     cdb0_we,
  input  logic [5:0]               cdb0_rrn,
  input  logic [XLEN-1:0]          cdb0_data,
  input  logic                     cdb1_we,
  input  logic [5:0]               cdb1_rrn,
  input  logic [XLEN-1:0]          cdb1_data,
  input  logic                     clear_tags,
  input  logic                     delete_tagged,
  output logic                     commit0_we,
  output logic [4:0]               commit0_arn,
  output logic [5:0]               commit0_rrn,
  output logic [XLEN-1:0]          commit0_data,
  output logic                     commit1_we,
  output logic [4:0]               commit1_arn,
  output logic [5:0]               commit1_rrn,
  output logic [XLEN-1:0]          commit1_data
`ifdef ROB_DEBUG_EN
  ,
  output logic [$clog2(DEPTH):0]   dbg_count,
  output logic [$clog2(DEPTH)-1:0] dbg_head,
  output logic [$clog2(DEPTH)-1:0] dbg_tail
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic            valid_q [DEPTH];
  logic            done_q  [DEPTH];
  logic            tag_q   [DEPTH];
  logic [4:0]      arn_q   [DEPTH];
  logic [5:0]      rrn_q   [DEPTH];
  logic [XLEN-1:0] data_q  [DEPTH];
  logic            valid_d [DEPTH];
  logic            done_d  [DEPTH];
  logic            tag_d   [DEPTH];
  logic [4:0]      arn_d   [DEPTH];
  logic [5:0]      rrn_d   [DEPTH];
  logic [XLEN-1:0] data_d  [DEPTH];

  logic [AW-1:0] head_q, head_d, tail_q, tail_d, head1, tail1, del_tail, idx;
  logic [CW-1:0] count_q, count_d, n_acc, n_ret, n_del;
  logic          acc0, acc1, ret0, ret1, found, spec_q;

  assign head1 = head_q + AW'(1);
  assign tail1 = tail_q + AW'(1);

  assign disp_ready = reset && (count_q <= CW'(DEPTH - 2)) && !delete_tagged;
  assign acc0 = disp_ready && disp0_valid;
  assign acc1 = acc0 && disp1_valid;

  // Retire decisions use the tags as they stand before any clear_tags this cycle.
  assign ret0 = valid_q[head_q] && done_q[head_q] && !tag_q[head_q];
  assign ret1 = ret0 && valid_q[head1] && done_q[head1] && !tag_q[head1];

  assign n_acc = CW'(acc0) + CW'(acc1);
  assign n_ret = CW'(ret0) + CW'(ret1);

  always_comb begin
    valid_d  = valid_q;
    done_d   = done_q;
    tag_d    = tag_q;
    arn_d    = arn_q;
    rrn_d    = rrn_q;
    data_d   = data_q;
    n_del    = '0;
    found    = 1'b0;
    del_tail = tail_q;
    idx      = head_q;

    if (ret0) valid_d[head_q] = 1'b0;
    if (ret1) valid_d[head1]  = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !done_q[i]) begin
        if (cdb0_we && rrn_q[i] == cdb0_rrn) begin
          done_d[i] = 1'b1;
          data_d[i] = cdb0_data;
        end else if (cdb1_we && rrn_q[i] == cdb1_rrn) begin
          done_d[i] = 1'b1;
          data_d[i] = cdb1_data;
        end
      end
    end

    // Tagged entries form a contiguous young suffix, so the oldest one is the new tail.
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + AW'(k);
      if (!found && valid_q[idx] && tag_q[idx]) begin
        found    = 1'b1;
        del_tail = idx;
      end
    end

    if (delete_tagged) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && tag_q[i]) begin
          valid_d[i] = 1'b0;
          n_del      = n_del + CW'(1);
        end
      end
    end else if (clear_tags) begin
      for (int i = 0; i < DEPTH; i++) tag_d[i] = 1'b0;
    end

    if (acc0) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      tag_d[tail_q]   = disp0_tag;
      arn_d[tail_q]   = disp0_arn;
      rrn_d[tail_q]   = disp0_rrn;
      data_d[tail_q]  = '0;
    end
    if (acc1) begin
      valid_d[tail1] = 1'b1;
      done_d[tail1]  = 1'b0;
      tag_d[tail1]   = disp1_tag;
      arn_d[tail1]   = disp1_arn;
      rrn_d[tail1]   = disp1_rrn;
      data_d[tail1]  = '0;
    end

    head_d  = head_q + AW'(n_ret);
    tail_d  = (delete_tagged && found) ? del_tail : tail_q + AW'(n_acc);
    count_d = count_q + n_acc - n_ret - n_del;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        done_q[i]  <= 1'b0;
        tag_q[i]   <= 1'b0;
        arn_q[i]   <= '0;
        rrn_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      tag_q   <= tag_d;
      arn_q   <= arn_d;
      rrn_q   <= rrn_d;
      data_q  <= data_d;
    end
  end

  // arn 0 is the hardwired zero register: the slot retires but nothing is written back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      commit0_we   <= 1'b0;
      commit0_arn  <= '0;
      commit0_rrn  <= '0;
      commit0_data <= '0;
      commit1_we   <= 1'b0;
      commit1_arn  <= '0;
      commit1_rrn  <= '0;
      commit1_data <= '0;
    end else begin
      commit0_we <= ret0 && (arn_q[head_q] != 5'd0);
      commit1_we <= ret1 && (arn_q[head1] != 5'd0);
      if (ret0) begin
        commit0_arn  <= arn_q[head_q];
        commit0_rrn  <= rrn_q[head_q];
        commit0_data <= data_q[head_q];
      end
      if (ret1) begin
        commit1_arn  <= arn_q[head1];
        commit1_rrn  <= rrn_q[head1];
        commit1_data <= data_q[head1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          spec_q <= 1'b0;
    else if (delete_tagged || clear_tags) spec_q <= 1'b0;
    else if ((acc0 && disp0_tag) || (acc1 && disp1_tag)) spec_q <= 1'b1;
  end

  assert property (@(posedge clk) disable iff (!reset)
    !((acc0 && !disp0_tag && spec_q) || (acc1 && !disp1_tag && (spec_q || disp0_tag))))
    else $error("untagged dispatch while a tagged entry is outstanding");

`ifdef ROB_DEBUG_EN
  assign dbg_count = count_q;
  assign dbg_head  = head_q;
  assign dbg_tail  = tail_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: expected commits are queued at stimulus time and
// matched by an independent monitor on the commit lanes.
module tb_reorder_buffer;
  logic        clk, reset;
  logic        disp0_valid, disp0_tag, disp1_valid, disp1_tag, disp_ready;
  logic [4:0]  disp0_arn, disp1_arn;
  logic [5:0]  disp0_rrn, disp1_rrn;
  logic        cdb0_we, cdb1_we;
  logic [5:0]  cdb0_rrn, cdb1_rrn;
  logic [31:0] cdb0_data, cdb1_data;
  logic        clear_tags, delete_tagged;
  logic        commit0_we, commit1_we;
  logic [4:0]  commit0_arn, commit1_arn;
  logic [5:0]  commit0_rrn, commit1_rrn;
  logic [31:0] commit0_data, commit1_data;

  logic [42:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int pair_cnt = 0;
  int pair_before;

  reorder_buffer #(.DEPTH(16), .XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .disp0_valid(disp0_valid), .disp0_arn(disp0_arn), .disp0_rrn(disp0_rrn), .disp0_tag(disp0_tag),
    .disp1_valid(disp1_valid), .disp1_arn(disp1_arn), .disp1_rrn(disp1_rrn), .disp1_tag(disp1_tag),
    .disp_ready(disp_ready),
    .cdb0_we(cdb0_we), .cdb0_rrn(cdb0_rrn), .cdb0_data(cdb0_data),
    .cdb1_we(cdb1_we), .cdb1_rrn(cdb1_rrn), .cdb1_data(cdb1_data),
    .clear_tags(clear_tags), .delete_tagged(delete_tagged),
    .commit0_we(commit0_we), .commit0_arn(commit0_arn), .commit0_rrn(commit0_rrn), .commit0_data(commit0_data),
    .commit1_we(commit1_we), .commit1_arn(commit1_arn), .commit1_rrn(commit1_rrn), .commit1_data(commit1_data)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [42:0] pk(input logic [4:0] a, input logic [5:0] r, input logic [31:0] d);
    return {a, r, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks: inputs are set just after a falling edge, consumed at the next rising edge
  task automatic idle();
    disp0_valid = 0; disp0_arn = 0; disp0_rrn = 0; disp0_tag = 0;
    disp1_valid = 0; disp1_arn = 0; disp1_rrn = 0; disp1_tag = 0;
    cdb0_we = 0; cdb0_rrn = 0; cdb0_data = 0;
    cdb1_we = 0; cdb1_rrn = 0; cdb1_data = 0;
    clear_tags = 0; delete_tagged = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    idle();
  endtask

  task automatic disp(input logic v0, input logic [4:0] a0, input logic [5:0] r0, input logic t0,
                      input logic v1, input logic [4:0] a1, input logic [5:0] r1, input logic t1);
    disp0_valid = v0; disp0_arn = a0; disp0_rrn = r0; disp0_tag = t0;
    disp1_valid = v1; disp1_arn = a1; disp1_rrn = r1; disp1_tag = t1;
    tick();
  endtask

  task automatic cdb(input logic w0, input logic [5:0] r0, input logic [31:0] d0,
                     input logic w1, input logic [5:0] r1, input logic [31:0] d1);
    cdb0_we = w0; cdb0_rrn = r0; cdb0_data = d0;
    cdb1_we = w1; cdb1_rrn = r1; cdb1_data = d1;
    tick();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard monitor
  task automatic sb_check(input string lane, input logic [4:0] a, input logic [5:0] r, input logic [31:0] d);
    logic [42:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s_unexpected: got arn=%0d rrn=%0d data=%0h expected no commit", lane, a, r, d);
    end else begin
      e = exp_q.pop_front();
      if (pk(a, r, d) !== e) begin
        miscompares++;
        $display("FAIL %s: got arn=%0d rrn=%0d data=%0h expected arn=%0d rrn=%0d data=%0h",
                 lane, a, r, d, e[42:38], e[37:32], e[31:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (commit0_we && commit1_we) pair_cnt++;
      if (commit1_we) chk("lane1_needs_lane0", 64'(commit0_we), 64'd1);
      if (commit0_we) sb_check("commit0", commit0_arn, commit0_rrn, commit0_data);
      if (commit1_we) sb_check("commit1", commit1_arn, commit1_rrn, commit1_data);
    end
  end

  initial begin
    idle();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ready", 64'(disp_ready), 64'd0);
    chk("reset_we0", 64'(commit0_we), 64'd0);
    chk("reset_we1", 64'(commit1_we), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("post_reset_ready", 64'(disp_ready), 64'd1);
    @(negedge clk);

    // basic out-of-order completion, paired retire
    pair_before = pair_cnt;
    exp_q.push_back(pk(5'd5, 6'd32, 32'hAAAA));
    exp_q.push_back(pk(5'd6, 6'd33, 32'hBBBB));
    disp(1, 5'd5, 6'd32, 0, 1, 5'd6, 6'd33, 0);
    cdb(1, 6'd33, 32'hBBBB, 0, 6'd0, 32'h0);
    cdb(0, 6'd0, 32'h0, 1, 6'd32, 32'hAAAA);
    drain("basic_drain");
    chk("basic_same_cycle", 64'(pair_cnt - pair_before), 64'd1);
    #1;
    chk("basic_ready", 64'(disp_ready), 64'd1);

    // fill to 15, free one, fill to 16, complete in reverse, through pointer wrap
    for (int d = 0; d < 7; d++) begin
      disp(1, 5'(1 + 2*d), 6'(32 + 2*d), 0, 1, 5'(2 + 2*d), 6'(33 + 2*d), 0);
      #1;
      chk($sformatf("fill_ready_%0d", d), 64'(disp_ready), 64'd1);
    end
    disp(1, 5'd15, 6'd46, 0, 0, 5'd0, 6'd0, 0);
    #1;
    chk("fill_ready_at_15", 64'(disp_ready), 64'd0);
    exp_q.push_back(pk(5'd1, 6'd32, 32'h1000));
    cdb(1, 6'd32, 32'h1000, 0, 6'd0, 32'h0);
    #1;
    chk("fill_ready_before_retire", 64'(disp_ready), 64'd0);
    tick();
    #1;
    chk("fill_ready_after_retire", 64'(disp_ready), 64'd1);
    disp(1, 5'd16, 6'd47, 0, 1, 5'd17, 6'd48, 0);
    #1;
    chk("fill_ready_at_16", 64'(disp_ready), 64'd0);
    for (int i = 1; i <= 16; i++) exp_q.push_back(pk(5'(1 + i), 6'(32 + i), 32'h1000 + i));
    for (int k = 16; k >= 2; k -= 2)
      cdb(1, 6'(32 + k), 32'h1000 + k, 1, 6'(31 + k), 32'h1000 + k - 1);
    drain("fill_drain");
    #1;
    chk("fill_ready_empty", 64'(disp_ready), 64'd1);

    // speculation kept by clear_tags
    disp(1, 5'd10, 6'd40, 0, 0, 5'd0, 6'd0, 0);
    disp(1, 5'd11, 6'd41, 1, 1, 5'd12, 6'd42, 1);
    exp_q.push_back(pk(5'd10, 6'd40, 32'h40));
    cdb(1, 6'd40, 32'h40, 1, 6'd41, 32'h41);
    cdb(1, 6'd42, 32'h42, 0, 6'd0, 32'h0);
    drain("tag_untagged_drain");
    repeat (4) tick();
    exp_q.push_back(pk(5'd11, 6'd41, 32'h41));
    exp_q.push_back(pk(5'd12, 6'd42, 32'h42));
    clear_tags = 1'b1;
    tick();
    drain("clear_tags_drain");

    // speculation discarded by delete_tagged
    disp(1, 5'd10, 6'd40, 0, 0, 5'd0, 6'd0, 0);
    disp(1, 5'd11, 6'd41, 1, 1, 5'd12, 6'd42, 1);
    exp_q.push_back(pk(5'd10, 6'd40, 32'h140));
    cdb(1, 6'd40, 32'h140, 1, 6'd41, 32'h141);
    cdb(1, 6'd42, 32'h142, 0, 6'd0, 32'h0);
    drain("delete_untagged_drain");
    repeat (4) tick();
    delete_tagged = 1'b1;
    #1;
    chk("delete_blocks_dispatch", 64'(disp_ready), 64'd0);
    tick();
    #1;
    chk("delete_ready_after", 64'(disp_ready), 64'd1);
    repeat (3) tick();
    disp(1, 5'd13, 6'd43, 0, 1, 5'd14, 6'd44, 0);
    exp_q.push_back(pk(5'd13, 6'd43, 32'h43));
    exp_q.push_back(pk(5'd14, 6'd44, 32'h44));
    cdb(1, 6'd44, 32'h44, 1, 6'd43, 32'h43);
    drain("delete_rewind_drain");

    // cdb0 priority on same rrn; arn 0 retires silently but frees its slot
    disp(1, 5'd7, 6'd35, 0, 1, 5'd0, 6'd36, 0);
    exp_q.push_back(pk(5'd7, 6'd35, 32'h1));
    cdb(1, 6'd35, 32'h1, 1, 6'd35, 32'h2);
    cdb(1, 6'd36, 32'h5, 0, 6'd0, 32'h0);
    drain("cdb_priority_drain");
    repeat (3) tick();
    disp(1, 5'd8, 6'd37, 0, 0, 5'd0, 6'd0, 0);
    exp_q.push_back(pk(5'd8, 6'd37, 32'h37));
    cdb(0, 6'd0, 32'h0, 1, 6'd37, 32'h37);
    drain("after_arn0_drain");

    // asynchronous reset while entries are live and retiring
    disp(1, 5'd20, 6'd50, 0, 1, 5'd21, 6'd51, 0);
    disp(1, 5'd22, 6'd52, 0, 1, 5'd23, 6'd53, 0);
    disp(1, 5'd24, 6'd54, 0, 0, 5'd0, 6'd0, 0);
    exp_q.push_back(pk(5'd20, 6'd50, 32'h50));
    exp_q.push_back(pk(5'd21, 6'd51, 32'h51));
    cdb(1, 6'd50, 32'h50, 1, 6'd51, 32'h51);
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_we0", 64'(commit0_we), 64'd0);
    chk("midreset_we1", 64'(commit1_we), 64'd0);
    chk("midreset_sb_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("midreset_ready", 64'(disp_ready), 64'd1);
    @(negedge clk);
    for (int d = 0; d < 7; d++) begin
      disp(1, 5'd1, 6'(32 + 2*d), 0, 1, 5'd2, 6'(33 + 2*d), 0);
      #1;
      chk($sformatf("refill_ready_%0d", d), 64'(disp_ready), 64'd1);
    end
    disp(1, 5'd3, 6'd46, 0, 0, 5'd0, 6'd0, 0);
    #1;
    chk("refill_ready_at_15", 64'(disp_ready), 64'd0);
    repeat (3) tick();
    chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement stage directly downstream of register renaming and execution.
- Accepts up to two renamed instructions per cycle from dispatch and snoops both common data buses for results.
- Retires completed entries in program order, up to two per cycle.
- Retire outputs drive the register file's commit write-back, which copies the renamed value to the architectural register and frees the rename register.
- Supports speculation: tagged entries cannot retire; they are either kept (clear_tags) or discarded (delete_tagged).

Parameters:
- DEPTH, 16, number of entries; power of two, at least 4.
- XLEN, 32, data width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- disp0_valid  input  1  dispatch slot 0 valid.
- disp0_arn  input  5  architectural destination register.
- disp0_rrn  input  6  rename register, range 32..63.
- disp0_tag  input  1  speculative entry.
- disp1_valid, disp1_arn, disp1_rrn, disp1_tag  input  1/5/6/1  dispatch slot 1, same meaning as slot 0.
- disp_ready  output  1  two free entries available.
- cdb0_we, cdb0_rrn, cdb0_data  input  1/6/XLEN  result bus 0.
- cdb1_we, cdb1_rrn, cdb1_data  input  1/6/XLEN  result bus 1.
- clear_tags  input  1  one-cycle pulse: clear the tag on all entries.
- delete_tagged  input  1  one-cycle pulse: discard all tagged entries.
- commit0_we, commit0_arn, commit0_rrn, commit0_data  output  1/5/6/XLEN  retire lane 0 (older).
- commit1_we, commit1_arn, commit1_rrn, commit1_data  output  1/5/6/XLEN  retire lane 1 (younger).

Behaviour:
- Storage: circular buffer with head, tail, and count (log2(DEPTH)+1 bits). Pointers wrap modulo DEPTH.
- Each entry holds: valid, done, tag, arn, rrn, data.
- Reset (reset=0, asynchronous): head, tail and count go to 0; all entries invalid; all outputs 0 (disp_ready is driven 1 once reset is released).
- disp_ready (combinational) = (DEPTH - count >= 2) && !delete_tagged.
- Dispatch (rising edge, disp_ready=1):
  - disp0 is written at tail, disp1 at tail+1; entries start with done=0.
  - disp1_valid is honoured only together with disp0_valid; disp1 alone is ignored.
  - tail and count advance by the number accepted.
- Tag ordering: once a tagged entry is dispatched, untagged dispatch is illegal until clear_tags or delete_tagged. A simulation-only assertion flags violations.
- CDB snoop:
  - Any valid entry with done=0 and rrn equal to cdbN_rrn while cdbN_we=1 captures cdbN_data and sets done=1 at the clock edge.
  - If both buses carry the same rrn, cdb0 wins.
  - Entries dispatched in the same cycle do not snoop.
- Retire (registered, one cycle):
  - Lane 0 retires the head entry when it is valid, done=1 and tag=0.
  - Lane 1 retires head+1 only when lane 0 retires in the same cycle and head+1 is valid, done=1 and tag=0.
  - commitN_* outputs are registered, valid the cycle after the edge at which the entry retired; commitN_we is cleared in every cycle with no retire.
  - Retired entries are invalidated; head advances and count decrements by the number retired.
  - An entry with arn=0 retires with commitN_we=0; its slot is still freed.
- Empty (count=0): no retire; commit_we stays 0.
- Full (count >= DEPTH-1): disp_ready=0.
- clear_tags: all entry tags go to 0 at the edge. Retire in the same cycle uses the pre-clear tags.
- delete_tagged:
  - All tagged entries are invalidated.
  - tail is set to the index of the oldest tagged entry; if no entry is tagged, tail is unchanged.
  - count is recomputed as count minus the number of deleted entries minus the number retired in that cycle.
  - Dispatch is blocked that cycle.
  - delete_tagged takes priority over a simultaneous clear_tags.
- Simultaneous dispatch and retire in one cycle: count changes by (accepted - retired).
- Reset asserted mid-operation discards all entries immediately, with no commit outputs.

Optional Feature:
- ROB_DEBUG_EN defined: adds output ports dbg_count (log2(DEPTH)+1 bits), dbg_head and dbg_tail (log2(DEPTH) bits each). All three are registered copies of the internal state and reset to 0.
- ROB_DEBUG_EN undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then dispatch (arn=5, rrn=32) and (arn=6, rrn=33); cdb0 writes rrn=33, data=0xBBBB; next cycle cdb1 writes rrn=32, data=0xAAAA -> one cycle later commit0 = (5, 32, 0xAAAA) and commit1 = (6, 33, 0xBBBB) in the same cycle; count returns to 0.
- Fill DEPTH=16 with 8 dual dispatches -> disp_ready=0 at count>=15. Complete and retire the head entry -> disp_ready=1 again. Continue through pointer wrap; retire order matches dispatch order.
- Dispatch untagged rrn=40, then tagged rrn=41 and rrn=42; complete all three -> only rrn=40 retires; clear_tags pulse -> rrn=41 and rrn=42 retire in the following cycles.
- Same setup as above, but with delete_tagged instead of clear_tags -> tail rewinds to the slot of rrn=41; count=0 after rrn=40 retires; no commit_we for rrn=41 or rrn=42.
- cdb0 and cdb1 both carry rrn=35 (data 0x1 and 0x2) -> the entry captures 0x1. Dispatch arn=0, rrn=36 and complete it -> the entry retires with commit_we=0.
- Assert reset (reset=0) while 5 entries are valid -> all commit_we=0 immediately; after release count=0 and disp_ready=1.
